pipe_skid_buffer: RTL and testbench
===================================

# pipe_skid_buffer

Two-entry elastic pipeline register that moves one WORD_SIZE-bit word per cycle between a producing stage and a consuming stage using valid/ready handshakes. It replaces a bare stage register where the downstream stage can stall. When the consumer stalls, the word already in flight is caught in a skid register, so the producer's ready does not depend combinationally on the consumer's ready. It sits between pipeline stages of the core, for example fetch→decode and decode→execute.

## Interface
- WORD_SIZE, 32, width of the data path in bits
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- in_valid  input  1  producer presents a word on in_data
- in_data  input  WORD_SIZE  producer word
- in_ready  output  1  buffer accepts a word this cycle
- out_valid  output  1  out_data holds a word for the consumer
- out_data  output  WORD_SIZE  word at the head of the buffer
- out_ready  input  1  consumer takes the head word this cycle
- count  output  2  number of words held: 0, 1 or 2
- flush  input  1  synchronous discard of all contents; the port exists only with PIPE_SKID_FLUSH_EN

## Operation
- Storage is two registers: main (head, drives out_data) and skid (second entry).
- The state machine has three states:
  - EMPTY: count=0
  - BUSY: count=1, main valid
  - FULL: count=2, main and skid valid
- A transfer happens only as follows:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Combinational outputs:
  - in_ready = reset & (state != FULL). It is forced to 0 while reset is low.
  - out_valid = (state != EMPTY).
- State transitions:
  - EMPTY, in_fire: main<=in_data → BUSY
  - EMPTY, no in_fire: stay EMPTY
  - BUSY, in_fire & out_fire: main<=in_data, stay BUSY
  - BUSY, in_fire only: skid<=in_data → FULL
  - BUSY, out_fire only → EMPTY
  - BUSY, neither: hold
  - FULL, out_fire: main<=skid → BUSY. in_fire is impossible in FULL.
  - FULL, no out_fire: hold
- Ordering is strictly FIFO: words leave in the order they were accepted. No word is ever dropped or duplicated, except by flush.
- out_data is stable and unchanged while out_valid=1 and out_ready=0.
- in_data is ignored whenever in_fire=0.
- Reset (reset low, at any time, including mid-transfer):
  - state becomes EMPTY, main=0, skid=0
  - outputs: out_valid=0, out_data=0, count=0, in_ready=0
  - after reset returns high, in_ready=1 with no clock edge needed

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N. Minimum one cycle through the buffer.
- Throughput: one word per cycle sustained when out_ready is held high.
- in_ready depends only on registered state, never on out_ready in the same cycle.
- After the consumer stalls with two words buffered, in_ready returns to 1 on the cycle after the first out_fire.
- count updates on the same edge as state.

## Configuration
- PIPE_SKID_FLUSH_EN defined:
  - the flush port exists
  - flush=1 at an edge forces state to EMPTY, clears main and skid to 0 and sets count=0
  - flush has priority over in_fire and out_fire in that cycle; a word offered in the same cycle is discarded, and the producer sees in_ready per the pre-edge state
  - flush in EMPTY is a no-op
- PIPE_SKID_FLUSH_EN undefined:
  - no flush port
  - only reset clears the contents

## Test plan
- Reset: drive reset low mid-stream with count=2 → out_valid=0, out_data=0, count=0, in_ready=0 immediately. After release, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with words 0x1, 0x2, 0x3 on consecutive cycles → out_data shows 0x1, 0x2, 0x3 on the following consecutive cycles, count=1 throughout.
- Stall and skid:
  - send 0xA then 0xB with out_ready=0 → count=2, in_ready=0, out_data=0xA held
  - then raise out_ready → 0xA, then 0xB, then out_valid=0
- Simultaneous in and out in BUSY: hold 0x5 in main, then in_fire of 0x6 with out_fire in the same cycle → next cycle out_data=0x6, count=1.
- Backpressure hold: in FULL, toggle in_valid and in_data randomly with out_ready=0 for 10 cycles → no state change, out_data unchanged.
- Flush (with PIPE_SKID_FLUSH_EN): in FULL with in_valid=1, data 0xC, and flush=1 → next cycle count=0, out_valid=0, and 0xC never appears on out_data.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer between pipeline stages.
// Optional synchronous flush port: define PIPE_SKID_FLUSH_EN.
module pipe_skid_buffer #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WORD_SIZE-1:0] r_main;
  logic [WORD_SIZE-1:0] r_skid;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_ld_main_in;
  logic                 w_ld_main_skid;
  logic                 w_ld_skid;
  logic                 w_flush;

`ifdef PIPE_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // State register; count is the state encoding itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and data-register load strobes.
  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_ld_main_in = 1'b1;
          w_next       = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_ld_skid = 1'b1;
          w_next    = FULL;
        end else if (w_out_fire) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_ld_main_skid = 1'b1;
          w_next         = BUSY;
        end
      end
      default: begin
        w_next = EMPTY;
      end
    endcase
    if (w_flush) begin
      w_next         = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // Head and skid storage; flush clears both like reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (w_flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= in_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
  end

  // Outputs from registered state only; in_ready masked by reset.
  always_comb begin
    in_ready  = reset & (r_state != FULL);
    out_valid = (r_state != EMPTY);
    out_data  = r_main;
    count     = r_state;
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Scoreboard bench for pipe_skid_buffer.
// Model tracks occupancy; queue tracks expected word order.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;
`ifdef PIPE_SKID_FLUSH_EN
  logic        flush;
`endif

  int          n_chk;
  int          n_fail;
  logic [31:0] q[$];
  int          m_count;
  logic        saw_c;

  pipe_skid_buffer #(.WORD_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PIPE_SKID_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare DUT to model, then advance the model.
  always @(negedge clk) begin
    logic ifire;
    logic ofire;
    if (!reset) begin
      q.delete();
      m_count = 0;
    end else begin
      chk("count", {30'd0, count}, m_count[31:0]);
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_count != 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_count != 0});
      ifire = in_valid && (m_count != 2);
      ofire = (m_count != 0) && out_ready;
      if (out_valid && out_data == 32'hC) saw_c = 1'b1;
`ifdef PIPE_SKID_FLUSH_EN
      if (flush) begin
        q.delete();
        m_count = 0;
        ifire = 1'b0;
        ofire = 1'b0;
      end
`endif
      if (ofire) begin
        chk("pop_ok", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) chk("data", out_data, q.pop_front());
        m_count--;
      end
      if (ifire) begin
        q.push_back(in_data);
        m_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && count == 2'd0) break;
      cyc(1);
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    m_count   = 0;
    saw_c     = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = 1'b0;
`endif
    cyc(2);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(1);

    // Streaming 1,2,3 at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      cyc(1);
      chk("stream_data", out_data, i);
      chk("stream_cnt", {30'd0, count}, 32'd1);
    end
    in_valid = 1'b0;
    cyc(2);

    // Stall and skid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cyc(1);
    in_data   = 32'hB;
    cyc(1);
    in_valid  = 1'b0;
    chk("skid_cnt", {30'd0, count}, 32'd2);
    chk("skid_rdy", {31'd0, in_ready}, 32'd0);
    chk("skid_head", out_data, 32'hA);
    out_ready = 1'b1;
    cyc(1);
    chk("skid_second", out_data, 32'hB);
    chk("skid_rdy_back", {31'd0, in_ready}, 32'd1);
    cyc(1);
    chk("skid_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous in/out while BUSY.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    cyc(1);
    in_data   = 32'h6;
    out_ready = 1'b1;
    cyc(1);
    chk("sim_data", out_data, 32'h6);
    chk("sim_cnt", {30'd0, count}, 32'd1);
    in_valid  = 1'b0;
    cyc(1);

    // Backpressure hold in FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    cyc(1);
    in_data   = 32'h22;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      cyc(1);
      chk("bp_cnt", {30'd0, count}, 32'd2);
      chk("bp_head", out_data, 32'h11);
    end

`ifdef PIPE_SKID_FLUSH_EN
    in_valid = 1'b1;
    in_data  = 32'hC;
    flush    = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_cnt", {30'd0, count}, 32'd0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_data", out_data, 32'd0);
    out_ready = 1'b1;
    cyc(3);
    chk("fl_no_c", {31'd0, saw_c}, 32'd0);
`endif
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom & 32'hFFFF_FFF0;
      out_ready = 1'($urandom_range(0, 3) != 0);
      cyc(1);
    end
    drain();

    // Async reset with two words held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    cyc(1);
    in_data   = 32'h88;
    cyc(1);
    in_valid  = 1'b0;
    chk("pre_rst_cnt", {30'd0, count}, 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_cnt", {30'd0, count}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    cyc(1);
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
